// File: rtl/ps2_rx_fifo_if.sv
// Key-event read port of the PS/2 receiver.
// The master side belongs to the receiver, and the slave side belongs to the consumer.
`timescale 1ns/1ps
interface ps2_rx_fifo_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          rd_en;
    logic          valid;
    logic [7:0]    code;
    logic          extended;
    logic          released;
    logic [CW-1:0] count;
    logic          overflow;
    logic          frame_err;

    modport master (
        input  rd_en,
        output valid, code, extended, released,
        output count, overflow, frame_err
    );

    modport slave (
        output rd_en,
        input  valid, code, extended, released,
        input  count, overflow, frame_err
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: it synchronises and filters the pins, decodes frames,
// folds E0/F0 prefixes into the key event, and buffers events in a FWFT FIFO.
`timescale 1ns/1ps
module ps2_rx_fifo #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 8,
    parameter int PARITY_CHECK   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic kb_clk,
    input  logic data,
    ps2_rx_fifo_if.master evt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] kc_sync;
    logic [SYNC_STAGES-1:0] d_sync;
    logic                   kc_s;
    logic                   d_s;
    logic                   kc_filt;
    logic                   kc_prev;
    logic [FW-1:0]          flt_cnt;
    logic                   fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            kc_sync <= '1;
            d_sync  <= '1;
        end else begin
            kc_sync <= {kc_sync[SYNC_STAGES-2:0], kb_clk};
            d_sync  <= {d_sync[SYNC_STAGES-2:0], data};
        end
    end

    assign kc_s = kc_sync[SYNC_STAGES-1];
    assign d_s  = d_sync[SYNC_STAGES-1];

    // The filtered clock moves only after FILTER_LEN samples in a row that disagree with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            kc_filt <= 1'b1;
            kc_prev <= 1'b1;
            flt_cnt <= '0;
        end else begin
            kc_prev <= kc_filt;
            if (kc_s == kc_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                kc_filt <= kc_s;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + FW'(1);
            end
        end
    end

    assign fall = kc_prev & ~kc_filt;

    state_t        st;
    state_t        st_n;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_cnt_n;
    logic [7:0]    shreg;
    logic [7:0]    shreg_n;
    logic          par_ok;
    logic          par_ok_n;
    logic          good_n;
    logic          good_q;
    logic          err_n;
    logic          err_q;
    logic [TW-1:0] tmo;
    logic          tmo_hit;

    assign tmo_hit = (st != S_IDLE) && !fall &&
                     (tmo == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        st_n      = st;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        par_ok_n  = par_ok;
        good_n    = 1'b0;
        err_n     = 1'b0;
        if (tmo_hit) begin
            st_n  = S_IDLE;
            err_n = 1'b1;
        end else if (fall) begin
            unique case (st)
                S_IDLE: begin
                    if (!d_s) begin
                        st_n      = S_DATA;
                        bit_cnt_n = 3'd0;
                    end
                end
                S_DATA: begin
                    shreg_n[bit_cnt] = d_s;
                    bit_cnt_n        = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) st_n = S_PARITY;
                end
                S_PARITY: begin
                    par_ok_n = (^{shreg, d_s}) | (PARITY_CHECK == 0);
                    st_n     = S_STOP;
                end
                S_STOP: begin
                    st_n = S_IDLE;
                    if (d_s && par_ok) good_n = 1'b1;
                    else err_n = 1'b1;
                end
                default: st_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= S_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par_ok  <= 1'b0;
            good_q  <= 1'b0;
            err_q   <= 1'b0;
            tmo     <= '0;
        end else begin
            st      <= st_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            par_ok  <= par_ok_n;
            good_q  <= good_n;
            err_q   <= err_n;
            tmo     <= (st == S_IDLE || fall) ? '0 : tmo + TW'(1);
        end
    end

    logic ext;
    logic brk;
    logic is_e0;
    logic is_f0;
    logic push;

    assign is_e0 = (shreg == 8'hE0);
    assign is_f0 = (shreg == 8'hF0);
    assign push  = good_q && !is_e0 && !is_f0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (err_q) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (good_q) begin
            if (is_e0) begin
                ext <= 1'b1;
            end else if (is_f0) begin
                brk <= 1'b1;
            end else begin
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] cnt;
    logic          ovf;
    logic          empty;
    logic          full;
    logic          pop;
    logic          wr;

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(FIFO_DEPTH));
    assign pop   = evt.rd_en && !empty;
    // When the FIFO is full, a simultaneous pop makes room for the push.
    assign wr    = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= {ext, brk, shreg};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            if (wr)  wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            if (wr && !pop) cnt <= cnt + CW'(1);
            else if (pop && !wr) cnt <= cnt - CW'(1);
            if (push && full && !pop) ovf <= 1'b1;
        end
    end

    assign evt.valid     = !empty;
    assign evt.code      = empty ? 8'h00 : mem[rp][7:0];
    assign evt.released  = empty ? 1'b0 : mem[rp][8];
    assign evt.extended  = empty ? 1'b0 : mem[rp][9];
    assign evt.count     = cnt;
    assign evt.overflow  = ovf;
    assign evt.frame_err = err_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: directed PS/2 frames drive a scoreboard queue,
// and a monitor compares every popped event and counts frame_err pulses.
`timescale 1ns/1ps
module tb_ps2_rx_fifo;
    localparam int CLK_HALF = 1250;
    localparam int HALF     = 20;

    logic clk;
    logic rst;
    logic kb_i;
    logic data_i;
    logic stim_rd;
    logic mon_rd;
    logic auto_rd;

    int total;
    int bad;
    int err_seen;
    int exp_err;

    logic [9:0] exp_q[$];

    ps2_rx_fifo_if #(.FIFO_DEPTH(8)) evt ();
    assign evt.rd_en = stim_rd | mon_rd;

    ps2_rx_fifo #(
        .SYNC_STAGES(2),
        .FILTER_LEN(4),
        .TIMEOUT_CYCLES(1000),
        .FIFO_DEPTH(8),
        .PARITY_CHECK(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kb_clk(kb_i),
        .data(data_i),
        .evt(evt)
    );

    initial clk = 1'b0;
    always #(CLK_HALF) clk = ~clk;

    initial begin
        #(CLK_HALF * 2 * 60000);
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    function automatic void push_exp(input bit e, input bit r,
                                     input logic [7:0] c);
        exp_q.push_back({e, r, c});
    endfunction

    // Monitor: sample after the falling edge and compare each pop against the queue.
    initial begin
        logic       err_prev;
        logic [9:0] e;
        err_prev = 1'b0;
        mon_rd   = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                mon_rd   = 1'b0;
                err_prev = 1'b0;
            end else begin
                mon_rd = auto_rd && evt.valid;
                if (evt.valid && (mon_rd || stim_rd)) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL pop_unexpected got=%h", evt.code);
                    end else begin
                        e = exp_q.pop_front();
                        if ({evt.extended, evt.released, evt.code} != e) begin
                            bad++;
                            $display("FAIL pop_event got=%b_%b_%h want=%b_%b_%h",
                                     evt.extended, evt.released, evt.code,
                                     e[9], e[8], e[7:0]);
                        end
                    end
                end
                if (evt.frame_err) begin
                    err_seen++;
                    total++;
                    if (err_prev) begin
                        bad++;
                        $display("FAIL frame_err_width got=2+ want=1");
                    end
                end
                err_prev = evt.frame_err;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic kb_bit(input bit b, input bit glitch, input int pop_at);
        @(negedge clk);
        data_i = b;
        if (glitch) begin
            idle(5);
            kb_i = 1'b0;
            idle(3);
            kb_i = 1'b1;
            idle(HALF - 8);
        end else begin
            idle(HALF);
        end
        kb_i = 1'b0;
        for (int i = 1; i <= HALF; i++) begin
            @(negedge clk);
            stim_rd = (i == pop_at);
        end
        kb_i = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par,
                              input bit bad_stop, input bit glitch,
                              input int pop_at);
        kb_bit(1'b0, glitch, 0);
        for (int i = 0; i < 8; i++) kb_bit(b[i], glitch, 0);
        kb_bit(~^b ^ bad_par, glitch, 0);
        kb_bit(~bad_stop, glitch, pop_at);
        @(negedge clk);
        data_i = 1'b1;
        idle(HALF);
    endtask

    task automatic good(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic drain(input string nm);
        int n;
        auto_rd = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || evt.valid) && n < 40) begin
            @(negedge clk);
            n++;
        end
        idle(2);
        auto_rd = 1'b0;
        chk({nm, "_drain_left"}, exp_q.size(), 0);
        chk({nm, "_drain_valid"}, int'(evt.valid), 0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        err_seen = 0;
        exp_err  = 0;
        rst      = 1'b1;
        kb_i     = 1'b1;
        data_i   = 1'b1;
        stim_rd  = 1'b0;
        auto_rd  = 1'b0;
        idle(3);
        #1;
        chk("rst_valid", int'(evt.valid), 0);
        chk("rst_code", int'(evt.code), 0);
        chk("rst_count", int'(evt.count), 0);
        chk("rst_overflow", int'(evt.overflow), 0);
        chk("rst_frame_err", int'(evt.frame_err), 0);
        rst = 1'b0;
        idle(5);

        // Single make code.
        push_exp(1'b0, 1'b0, 8'h1C);
        good(8'h1C);
        #1;
        chk("t1_valid", int'(evt.valid), 1);
        chk("t1_code", int'(evt.code), 8'h1C);
        chk("t1_ext", int'(evt.extended), 0);
        chk("t1_rel", int'(evt.released), 0);
        chk("t1_count", int'(evt.count), 1);
        @(negedge clk);
        stim_rd = 1'b1;
        @(negedge clk);
        stim_rd = 1'b0;
        #1;
        chk("t1_pop_valid", int'(evt.valid), 0);
        chk("t1_pop_count", int'(evt.count), 0);
        chk("t1_sb_left", exp_q.size(), 0);

        // Prefix folding.
        push_exp(1'b0, 1'b1, 8'h1C);
        push_exp(1'b1, 1'b1, 8'h75);
        good(8'hF0);
        good(8'h1C);
        good(8'hE0);
        good(8'hF0);
        good(8'h75);
        #1;
        chk("t2_count", int'(evt.count), 2);
        drain("t2");

        // Parity and stop errors, including a break prefix lost with a bad frame.
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0, 0);
        exp_err++;
        push_exp(1'b0, 1'b0, 8'h1C);
        good(8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 0);
        exp_err++;
        push_exp(1'b0, 1'b0, 8'h1C);
        good(8'h1C);
        good(8'hF0);
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0, 0);
        exp_err++;
        push_exp(1'b0, 1'b0, 8'h1C);
        good(8'h1C);
        #1;
        chk("t3_errs", err_seen, exp_err);
        chk("t3_count", int'(evt.count), 3);
        drain("t3");

        // Overflow, then a simultaneous push and pop while full.
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) push_exp(1'b0, 1'b0, 8'(i));
            good(8'(i));
        end
        #1;
        chk("t4_count_full", int'(evt.count), 8);
        chk("t4_overflow", int'(evt.overflow), 1);
        push_exp(1'b0, 1'b0, 8'h0A);
        send_frame(8'h0A, 1'b0, 1'b0, 1'b0, 7);
        #1;
        chk("t4_count_pp", int'(evt.count), 8);
        chk("t4_overflow_pp", int'(evt.overflow), 1);
        drain("t4");

        // Timeout of a partial frame.
        kb_bit(1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++) kb_bit(1'b1, 1'b0, 0);
        idle(900);
        #1;
        chk("t5_no_early_err", err_seen, exp_err);
        idle(200);
        exp_err++;
        #1;
        chk("t5_timeout_err", err_seen, exp_err);
        push_exp(1'b0, 1'b0, 8'h2A);
        good(8'h2A);
        #1;
        chk("t5_count", int'(evt.count), 1);
        drain("t5");

        // Short low glitches on kb_clk in every bit.
        push_exp(1'b0, 1'b0, 8'h1B);
        send_frame(8'h1B, 1'b0, 1'b0, 1'b1, 0);
        #1;
        chk("t6_errs", err_seen, exp_err);
        chk("t6_count", int'(evt.count), 1);
        drain("t6");

        // Reset in the middle of a frame.
        kb_bit(1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) kb_bit(1'b1, 1'b0, 0);
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(HALF);
        #1;
        chk("t7_count", int'(evt.count), 0);
        chk("t7_overflow", int'(evt.overflow), 0);
        chk("t7_errs", err_seen, exp_err);
        push_exp(1'b0, 1'b0, 8'h4B);
        good(8'h4B);
        #1;
        chk("t7_count_after", int'(evt.count), 1);
        drain("t7");

        chk("final_errs", err_seen, exp_err);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- PS/2 keyboard receiver for the system clock domain: kb_clk and data are synchronised and glitch-filtered, and frames are sampled on filtered kb_clk falling edges.
- Start, parity and stop bits are checked.
- E0/F0 prefixes are folded into the following scan code, and complete key events are buffered in a first-word-fall-through FIFO.
- Successor of the single-byte keycode receiver; feeds the game input/control logic.

Parameters:
SYNC_STAGES, 2, flip-flop stages on kb_clk and data (min 2)
FILTER_LEN, 4, consecutive equal synchronised samples required before the filtered kb_clk changes (min 1)
TIMEOUT_CYCLES, 50000, clk cycles without a falling edge before a partial frame is aborted
FIFO_DEPTH, 8, event FIFO entries (power of 2, min 2)
PARITY_CHECK, 1, 1 = enforce odd parity; 0 = ignore the parity bit

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
kb_clk  in  1  PS/2 clock, asynchronous
data  in  1  PS/2 data, asynchronous
rd_en  in  1  pop head entry; ignored when valid=0
valid  out  1  FIFO not empty
code  out  8  head scan code
extended  out  1  head event carried an E0 prefix
released  out  1  head event carried an F0 prefix (key break)
count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
overflow  out  1  sticky: an event was dropped because the FIFO was full
frame_err  out  1  one-cycle pulse when a frame is discarded

Behaviour:
- Reset (rst=1 at a clk edge):
  - FSM to IDLE; bit counter, shift register, prefix flags and timeout counter cleared.
  - FIFO emptied; all outputs 0.
  - Synchronisers and filter preset to 1 (bus idle).
  - Reset mid-frame discards the partial frame; no frame_err.
- Input conditioning:
  - Filtered kb_clk toggles only after FILTER_LEN consecutive equal synchronised samples.
  - A fall event is a one-cycle strobe on its 1->0 transition.
  - data is sampled from its synchroniser output in the fall-event cycle.
- FSM: IDLE -> DATA -> PARITY -> STOP -> IDLE, advancing on fall events only.
  - IDLE: sample 0 -> DATA with bit count 0. Sample 1 -> stay in IDLE silently.
  - DATA: 8 bits, LSB first, shifted into bit[n]. After the 8th bit -> PARITY.
  - PARITY: pass if the 9 bits (data + parity) contain an odd number of ones, or PARITY_CHECK=0. -> STOP regardless; the result is latched.
  - STOP: sample 1 and parity passed -> frame good. Otherwise -> frame_err pulse. -> IDLE in all cases.
- Timeout:
  - The counter runs while FSM != IDLE and resets on every fall event.
  - Reaching TIMEOUT_CYCLES -> IDLE plus frame_err pulse.
- Any discarded frame also clears both prefix flags.
- Good-frame handling, in the cycle after the STOP fall event:
  - 0xE0 -> set ext flag; no push.
  - 0xF0 -> set brk flag; no push.
  - Any other byte -> push {ext, brk, byte}, then clear both flags.
- FIFO:
  - Circular, with pointers of width log2(FIFO_DEPTH) that wrap naturally.
  - Head (code/extended/released) is valid combinationally while valid=1.
  - Push to pop latency: valid rises the cycle after the push.
  - Push while full and no pop: entry dropped, overflow set to 1 until rst.
  - Push and pop in the same cycle:
    - Both take effect and count is unchanged.
    - This applies even when full (no overflow).
    - When empty, only the push takes effect.
  - rd_en with valid=0: no effect; count never underflows.
- Latency: from the kb_clk falling pin edge to the fall event is SYNC_STAGES+FILTER_LEN clk cycles (±1).

Test Plan:
- Frame byte 0x1C (LSB-first bits 0,0,1,1,1,0,0,0; parity 0; stop 1) at a 10 kHz kb_clk -> valid=1, code=0x1C, extended=0, released=0, count=1; rd_en 1 cycle -> valid=0, count=0.
- Frames F0, 1C then E0, F0, 75 -> exactly two entries: {0x1C, ext=0, rel=1}, then {0x75, ext=1, rel=1}; count=2.
- Frame 0x1C with parity bit 1, then frame 0x1C good; repeat with stop bit 0 -> frame_err pulses for 1 cycle each time; only the good frames are pushed. Same with F0 before the bad frame -> the next good 0x1C has rel=0.
- Nine good frames 0x01..0x09 with no reads (FIFO_DEPTH=8) -> count=8, overflow=1; pops return 0x01..0x08 in order. Push and pop in the same cycle while full -> count stays 8, overflow unchanged.
- Start bit plus 4 data bits, then kb_clk held high, with TIMEOUT_CYCLES=1000 -> frame_err pulse after 1000 cycles; FSM in IDLE; the next frame 0x2A decodes correctly.
- kb_clk low glitches shorter than FILTER_LEN cycles injected mid-frame -> no extra bits sampled; frame decodes correctly. rst asserted mid-frame -> no push, no frame_err; the following frame decodes correctly.
